// File: rtl/iot_event_encoder_if.sv
// Device-event bus between the status registers/monitor side and the encoder.
// The encoder side (slave) samples dev_status/en and drives the event strobe and counters.
interface iot_event_encoder_if #(
    parameter int N_DEV = 8,
    parameter int CNT_W = 8,
    parameter int ID_W  = 3
);
    logic [N_DEV-1:0] dev_status;
    logic             en;
    logic             change;
    logic             on_off;
    logic [ID_W-1:0]  dev_id;
    logic [CNT_W-1:0] active_count;
    logic [CNT_W-1:0] pending;

    modport master (
        output dev_status, en,
        input  change, on_off, dev_id, active_count, pending
    );

    modport slave (
        input  dev_status, en,
        output change, on_off, dev_id, active_count, pending
    );
endinterface

// File: rtl/iot_event_encoder.sv
// Emits one change/on_off event per clock for devices whose level differs from
// the last reported state, scanning round-robin from the device after the last one served.
module iot_event_encoder #(
    parameter int N_DEV = 8,
    parameter int CNT_W = 8,
    parameter int ID_W  = 3
) (
    input  logic                clk,
    input  logic                rst,
    iot_event_encoder_if.slave  bus
);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_DEV - 1);

    logic [N_DEV-1:0] shadow_q, shadow_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [ID_W-1:0]  dev_id_q, dev_id_d;
    logic             change_q, change_d;
    logic             on_off_q, on_off_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [N_DEV-1:0] diff;
    logic [CNT_W-1:0] pending_c;
    logic             found;
    logic [ID_W-1:0]  sel;
    logic [ID_W-1:0]  scan;
    logic [ID_W-1:0]  sel_next;

    always_comb begin
        diff = bus.dev_status ^ shadow_q;
    end

    always_comb begin
        pending_c = '0;
        for (int k = 0; k < N_DEV; k++) begin
            pending_c = pending_c + {{(CNT_W-1){1'b0}}, diff[k]};
        end
    end

    // Wrapping increment keeps scan indices inside 0..N_DEV-1 even when N_DEV is not a power of two.
    always_comb begin
        found = 1'b0;
        sel   = ptr_q;
        scan  = ptr_q;
        for (int k = 0; k < N_DEV; k++) begin
            if (!found && diff[scan]) begin
                found = 1'b1;
                sel   = scan;
            end
            scan = (scan == LAST_ID) ? '0 : scan + ID_W'(1);
        end
        sel_next = (sel == LAST_ID) ? '0 : sel + ID_W'(1);
    end

    always_comb begin
        shadow_d = shadow_q;
        ptr_d    = ptr_q;
        dev_id_d = dev_id_q;
        on_off_d = on_off_q;
        count_d  = count_q;
        change_d = 1'b0;
        if (bus.en && found) begin
            change_d       = 1'b1;
            on_off_d       = bus.dev_status[sel];
            dev_id_d       = sel;
            shadow_d[sel]  = bus.dev_status[sel];
            ptr_d          = sel_next;
            count_d        = bus.dev_status[sel] ? count_q + CNT_W'(1) : count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= '0;
            ptr_q    <= '0;
            dev_id_q <= '0;
            change_q <= 1'b0;
            on_off_q <= 1'b0;
            count_q  <= '0;
        end else begin
            shadow_q <= shadow_d;
            ptr_q    <= ptr_d;
            dev_id_q <= dev_id_d;
            change_q <= change_d;
            on_off_q <= on_off_d;
            count_q  <= count_d;
        end
    end

    assign bus.change       = change_q;
    assign bus.on_off       = on_off_q;
    assign bus.dev_id       = dev_id_q;
    assign bus.active_count = count_q;
    assign bus.pending      = pending_c;
endmodule

// File: tb/tb_iot_event_encoder.sv
// Self-checking bench for iot_event_encoder: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a behavioural model.
module tb_iot_event_encoder;
    localparam int N_DEV = 8;
    localparam int CNT_W = 8;
    localparam int ID_W  = 3;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    iot_event_encoder_if #(.N_DEV(N_DEV), .CNT_W(CNT_W), .ID_W(ID_W)) bus ();

    iot_event_encoder #(.N_DEV(N_DEV), .CNT_W(CNT_W), .ID_W(ID_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: last-reported state per device, scan start, reported-on count.
    bit m_shadow[N_DEV];
    int m_ptr;
    int m_count;
    bit e_change;
    bit e_on_off;
    int e_id;
    bit started;

    always @(posedge clk) begin
        if (rst) begin
            foreach (m_shadow[i]) m_shadow[i] = 1'b0;
            m_ptr    = 0;
            m_count  = 0;
            e_change = 1'b0;
            e_on_off = 1'b0;
            e_id     = 0;
            started  = 1'b1;
        end else if (started) begin
            e_change = 1'b0;
            if (bus.en) begin
                for (int k = 0; k < N_DEV; k++) begin
                    int i;
                    i = (m_ptr + k) % N_DEV;
                    if (m_shadow[i] != bus.dev_status[i]) begin
                        e_change    = 1'b1;
                        e_on_off    = bus.dev_status[i];
                        e_id        = i;
                        m_shadow[i] = bus.dev_status[i];
                        m_ptr       = (i + 1) % N_DEV;
                        m_count     = m_count + (bus.dev_status[i] ? 1 : -1);
                        break;
                    end
                end
            end
        end
        #2;
        if (started) begin
            int exp_pending;
            exp_pending = 0;
            for (int i = 0; i < N_DEV; i++)
                if (m_shadow[i] != bus.dev_status[i]) exp_pending++;
            chk("model_change", int'(bus.change), int'(e_change));
            chk("model_on_off", int'(bus.on_off), int'(e_on_off));
            chk("model_dev_id", int'(bus.dev_id), e_id);
            chk("model_active_count", int'(bus.active_count), m_count);
            chk("model_pending", int'(bus.pending), exp_pending);
        end
    end

    // Advance one clock; returns 3 time units after the edge, after the model compare.
    task automatic cyc();
        @(posedge clk);
        #3;
    endtask

    task automatic expect_event(input string name, input int id, input int on);
        cyc();
        chk({name, "_change"}, int'(bus.change), 1);
        chk({name, "_id"}, int'(bus.dev_id), id);
        chk({name, "_on_off"}, int'(bus.on_off), on);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        started = 1'b0;
        rst = 1'b1;
        bus.en = 1'b0;
        bus.dev_status = 8'hFF;

        // Reset held two cycles with all devices on.
        for (int r = 0; r < 2; r++) begin
            cyc();
            chk("rst_change", int'(bus.change), 0);
            chk("rst_count", int'(bus.active_count), 0);
            chk("rst_pending", int'(bus.pending), 8);
        end

        // Two devices come on.
        rst = 1'b0;
        bus.en = 1'b1;
        bus.dev_status = 8'h05;
        expect_event("t2_ev0", 0, 1);
        expect_event("t2_ev1", 2, 1);
        cyc();
        chk("t2_idle", int'(bus.change), 0);
        chk("t2_count", int'(bus.active_count), 2);
        chk("t2_pending", int'(bus.pending), 0);

        // Both go off; scan from ptr=3 wraps to 0.
        bus.dev_status = 8'h00;
        expect_event("t3_ev0", 0, 0);
        expect_event("t3_ev1", 2, 0);
        cyc();
        chk("t3_idle", int'(bus.change), 0);
        chk("t3_count", int'(bus.active_count), 0);

        // Hold while disabled, then release in pointer order.
        bus.en = 1'b0;
        bus.dev_status = 8'h81;
        for (int r = 0; r < 3; r++) begin
            cyc();
            chk("t4_hold_change", int'(bus.change), 0);
            chk("t4_hold_pending", int'(bus.pending), 2);
        end
        bus.en = 1'b1;
        expect_event("t4_ev0", 7, 1);
        expect_event("t4_ev1", 0, 1);
        cyc();
        chk("t4_count", int'(bus.active_count), 2);

        // Bit 3 toggles back before any scan: no event.
        bus.en = 1'b0;
        bus.dev_status = 8'h89;
        cyc();
        bus.dev_status = 8'h81;
        cyc();
        bus.en = 1'b1;
        cyc();
        chk("t5_no_event", int'(bus.change), 0);
        cyc();
        chk("t5_no_event2", int'(bus.change), 0);
        chk("t5_count", int'(bus.active_count), 2);

        // Reset mid-stream drops the next strobe and clears state.
        bus.dev_status = 8'hFF;
        expect_event("t6_pre0", 1, 1);
        expect_event("t6_pre1", 2, 1);
        expect_event("t6_pre2", 3, 1);
        rst = 1'b1;
        cyc();
        chk("t6_rst_change", int'(bus.change), 0);
        chk("t6_rst_count", int'(bus.active_count), 0);
        chk("t6_rst_id", int'(bus.dev_id), 0);
        chk("t6_rst_pending", int'(bus.pending), 8);
        rst = 1'b0;
        for (int i = 0; i < N_DEV; i++) begin
            expect_event("t6_post", i, 1);
            chk("t6_post_count", int'(bus.active_count), i + 1);
        end
        cyc();
        chk("t6_final_idle", int'(bus.change), 0);
        chk("t6_final_count", int'(bus.active_count), 8);

        // Randomized traffic, checked each cycle by the model.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 2) == 0)
                bus.dev_status = bus.dev_status ^ 8'($urandom);
            bus.en = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 199) == 0);
            cyc();
        end
        rst = 1'b0;
        bus.en = 1'b1;
        for (int n = 0; n < N_DEV + 2; n++) cyc();
        chk("final_drained_pending", int'(bus.pending), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
